// File: rtl/pawn_move_ctrl.sv
// pawn_move_ctrl: latches a pawn source, feeds the rule checker, judges the destination and tracks turn/move count.
module pawn_move_ctrl #(
    parameter int TIMEOUT = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sel_valid,
    input  logic [5:0] sel_pos,
    input  logic       piece_ok,
    output logic [5:0] chk_pos,
    output logic       chk_color,
    input  logic [2:0] chk_allow,
    output logic       move_valid,
    output logic [5:0] move_src,
    output logic [5:0] move_dst,
    output logic       move_err,
    output logic [1:0] err_code,
    output logic       turn,
    output logic [7:0] move_count,
    output logic       busy
);
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SRC, WAIT_DST, CHECK} state_t;

    state_t          state, next;
    logic [5:0]      src, dst;
    logic [2:0]      allow_q;
    logic [CW-1:0]   cnt;
    logic            expired, legal;
    logic signed [6:0] d;
    logic [2:0]      f;

    assign chk_pos   = src;
    assign chk_color = turn;
    assign expired   = cnt == CW'(TIMEOUT - 1);
    assign d         = 7'({1'b0, dst}) - 7'({1'b0, src});
    assign f         = src[2:0];

    // Pawn legality from the sampled checker result plus file-edge guards against board wrap.
    always_comb begin
        legal = turn ? ((d == -7'sd8  && allow_q[0]) ||
                        (d == -7'sd16 && allow_q[1]) ||
                        (d == -7'sd9  && allow_q[2] && f != 3'd0) ||
                        (d == -7'sd7  && allow_q[2] && f != 3'd7))
                     : ((d == 7'sd8   && allow_q[0]) ||
                        (d == 7'sd16  && allow_q[1]) ||
                        (d == 7'sd7   && allow_q[2] && f != 3'd0) ||
                        (d == 7'sd9   && allow_q[2] && f != 3'd7));
    end

    // State register.
    always_ff @(posedge clk) begin
        state <= !reset ? IDLE : next;
    end

    // Next-state selection; a strobe in WAIT_DST takes priority over the timeout.
    always_comb begin
        next = state;
        case (state)
            IDLE:     next = (sel_valid && piece_ok) ? SRC : IDLE;
            SRC:      next = WAIT_DST;
            WAIT_DST: next = sel_valid ? ((sel_pos == src) ? IDLE : CHECK) : (expired ? IDLE : WAIT_DST);
            default:  next = IDLE;
        endcase
    end

    // Datapath registers and registered output pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            src        <= '0;
            dst        <= '0;
            allow_q    <= '0;
            cnt        <= '0;
            move_valid <= 1'b0;
            move_err   <= 1'b0;
            err_code   <= 2'b00;
            move_src   <= '0;
            move_dst   <= '0;
            turn       <= 1'b0;
            move_count <= '0;
            busy       <= 1'b0;
        end else begin
            move_valid <= 1'b0;
            move_err   <= 1'b0;
            busy       <= next != IDLE;
            case (state)
                IDLE: begin
                    if (sel_valid && piece_ok) src <= sel_pos;
                    if (sel_valid && !piece_ok) begin
                        move_err <= 1'b1;
                        err_code <= 2'b11;
                    end
                end
                SRC: begin
                    allow_q <= chk_allow;
                    cnt     <= '0;
                end
                WAIT_DST: begin
                    if (sel_valid) begin
                        if (sel_pos != src) dst <= sel_pos;
                    end else if (expired) begin
                        move_err <= 1'b1;
                        err_code <= 2'b10;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (legal) begin
                        move_valid <= 1'b1;
                        move_src   <= src;
                        move_dst   <= dst;
                        turn       <= ~turn;
                        move_count <= move_count + 8'd1;
                    end else begin
                        move_err <= 1'b1;
                        err_code <= 2'b01;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_pawn_move_ctrl.sv
// tb_pawn_move_ctrl: directed vectors against hand-computed results for pawn_move_ctrl.
module tb_pawn_move_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sel_valid = 1'b0;
    logic [5:0] sel_pos = '0;
    logic       piece_ok = 1'b0;
    logic [2:0] chk_allow = '0;
    logic [5:0] chk_pos, move_src, move_dst;
    logic       chk_color, move_valid, move_err, turn, busy;
    logic [1:0] err_code;
    logic [7:0] move_count;
    int         n_vec = 0;
    int         n_err = 0;

    pawn_move_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .sel_valid(sel_valid), .sel_pos(sel_pos),
        .piece_ok(piece_ok), .chk_pos(chk_pos), .chk_color(chk_color),
        .chk_allow(chk_allow), .move_valid(move_valid), .move_src(move_src),
        .move_dst(move_dst), .move_err(move_err), .err_code(err_code),
        .turn(turn), .move_count(move_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [5:0] pos, input logic ok);
        sel_valid = 1'b1;
        sel_pos   = pos;
        piece_ok  = ok;
        tick();
        sel_valid = 1'b0;
        piece_ok  = 1'b0;
    endtask

    task automatic do_move(input logic [5:0] s, input logic [5:0] t);
        strobe(s, 1'b1);
        tick();
        strobe(t, 1'b1);
        tick();
    endtask

    initial begin
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_turn", turn, 0);
        check("rst_count", move_count, 0);
        check("rst_err", {move_valid, move_err, err_code}, 0);
        check("rst_chk", {chk_pos, chk_color}, 0);
        check("rst_move", {move_src, move_dst}, 0);
        reset = 1'b1;
        tick();

        chk_allow = 3'b011;
        strobe(6'd12, 1'b1);
        check("src_busy", busy, 1);
        check("src_chkpos", chk_pos, 12);
        check("src_color", chk_color, 0);
        tick();
        strobe(6'd28, 1'b1);
        check("chk_nopulse", {move_valid, move_err}, 0);
        check("chk_busy", busy, 1);
        tick();
        check("dbl_valid", move_valid, 1);
        check("dbl_err", move_err, 0);
        check("dbl_src", move_src, 12);
        check("dbl_dst", move_dst, 28);
        check("dbl_turn", turn, 1);
        check("dbl_count", move_count, 1);
        check("dbl_busy", busy, 0);
        tick();
        check("dbl_pulse1", move_valid, 0);
        check("dbl_hold", move_dst, 28);

        chk_allow = 3'b100;
        do_move(6'd48, 6'd39);
        check("wrap_err", move_err, 1);
        check("wrap_valid", move_valid, 0);
        check("wrap_code", err_code, 1);
        check("wrap_turn", turn, 1);
        check("wrap_count", move_count, 1);

        do_move(6'd55, 6'd48);
        check("edge7_err", {move_err, err_code}, 3'b101);

        strobe(6'd50, 1'b1);
        tick();
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("to_wait_err", move_err, 0);
            check("to_wait_busy", busy, 1);
        end
        tick();
        check("to_err", move_err, 1);
        check("to_code", err_code, 2);
        check("to_busy", busy, 0);

        strobe(6'd50, 1'b1);
        tick();
        strobe(6'd50, 1'b1);
        check("cancel_busy", busy, 0);
        check("cancel_pulse", {move_valid, move_err}, 0);
        tick();
        check("cancel_pulse2", {move_valid, move_err}, 0);
        check("cancel_code", err_code, 2);
        strobe(6'd20, 1'b0);
        check("wp_err", move_err, 1);
        check("wp_code", err_code, 3);
        check("wp_busy", busy, 0);
        tick();
        check("wp_pulse1", move_err, 0);

        chk_allow = 3'b010;
        strobe(6'd52, 1'b1);
        strobe(6'd60, 1'b1);
        check("ign_src_busy", busy, 1);
        strobe(6'd36, 1'b1);
        strobe(6'd44, 1'b1);
        check("ign_valid", move_valid, 1);
        check("ign_src", move_src, 52);
        check("ign_dst", move_dst, 36);
        check("ign_turn", turn, 0);
        check("ign_count", move_count, 2);

        strobe(6'd12, 1'b1);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mr_busy", busy, 0);
        check("mr_turn", turn, 0);
        check("mr_count", move_count, 0);
        check("mr_pulse", {move_valid, move_err, err_code}, 0);
        check("mr_chkpos", chk_pos, 0);
        tick();
        check("mr_pulse2", {move_valid, move_err}, 0);
        chk_allow = 3'b001;
        do_move(6'd8, 6'd16);
        check("mr_valid", move_valid, 1);
        check("mr_dst", move_dst, 16);
        check("mr_turn2", turn, 1);
        check("mr_count2", move_count, 1);

        do_move(6'd52, 6'd43);
        check("bad_d_err", {move_err, err_code}, 3'b101);

        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 256; i++) begin
            if (i % 2 == 0) do_move(6'd8, 6'd16);
            else do_move(6'd48, 6'd40);
            if (i == 254) begin
                check("w255_count", move_count, 255);
                check("w255_turn", turn, 1);
            end
        end
        check("wrap_valid", move_valid, 1);
        check("wrap_count0", move_count, 0);
        check("wrap_turn0", turn, 0);

        chk_allow = 3'b100;
        do_move(6'd15, 6'd24);
        check("w9f7_err", {move_err, err_code}, 3'b101);
        do_move(6'd8, 6'd15);
        check("w7f0_err", {move_err, err_code}, 3'b101);
        do_move(6'd9, 6'd18);
        check("w9_valid", move_valid, 1);
        check("w9_count", move_count, 1);
        check("w9_turn", turn, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pawn_move_ctrl.md
# pawn_move_ctrl

Turn-sequencing controller that sits between the board's square-select input and the combinational pawn rule checker. It latches a source square for the side to move and drives that square into the shared checker. It then waits for a destination square, decides legality from the checker's `allow` vector plus board geometry, and emits a one-cycle commit or error pulse. It also owns the side-to-move flag, a move counter and a destination-selection timeout.

## Interface
- `TIMEOUT`, default 1000: cycles allowed in WAIT_DST before the move is aborted; minimum 2.
- `clk`  in  1  clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-low reset.
- `sel_valid`  in  1  one-cycle strobe: a square was selected.
- `sel_pos`  in  6  selected square, `{rank[2:0], file[2:0]}`; rank 0 is white's back rank.
- `piece_ok`  in  1  board lookup result, sampled with `sel_valid` in IDLE: 1 means `sel_pos` holds a pawn of the side to move.
- `chk_pos`  out  6  square presented to the pawn checker; this is the registered source.
- `chk_color`  out  1  colour presented to the checker: 0 white, 1 black.
- `chk_allow`  in  3  checker result: [0] single step, [1] double step, [2] diagonal capture.
- `move_valid`  out  1  one-cycle pulse: legal move committed.
- `move_src`, `move_dst`  out  6 each  move squares; stable from the pulse until the next commit.
- `move_err`  out  1  one-cycle pulse: attempt rejected.
- `err_code`  out  2  01 illegal, 10 timeout, 11 wrong piece; holds its value until the next `move_err`.
- `turn`  out  1  side to move: 0 white, 1 black.
- `move_count`  out  8  committed moves; wraps 255 to 0.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, SRC, WAIT_DST, CHECK.
- IDLE:
  - `sel_valid` with `piece_ok`=1: latch `src`=`sel_pos`, go to SRC.
  - `sel_valid` with `piece_ok`=0: pulse `move_err`, set `err_code`=11, stay in IDLE.
- SRC: `chk_pos`=`src`, `chk_color`=`turn`. Register `chk_allow` into `allow_q`, clear the timeout counter, go to WAIT_DST. `sel_valid` is ignored here.
- WAIT_DST:
  - `sel_valid` with `sel_pos`==`src`: cancel, return to IDLE with no pulse.
  - Any other `sel_valid`: latch `dst`, go to CHECK.
  - No `sel_valid`: the counter increments. When the counter equals TIMEOUT-1, pulse `move_err` with `err_code`=10 and go to IDLE.
  - `sel_valid` on the terminal cycle wins over the timeout.
- CHECK: `sel_valid` is ignored. Legality is computed in 7-bit signed arithmetic, d = `dst` − `src`, f = file of `src`.
  - White (`turn`=0):
    - d=+8 needs `allow_q[0]`.
    - d=+16 needs `allow_q[1]`.
    - d=+7 needs `allow_q[2]` and f≠0.
    - d=+9 needs `allow_q[2]` and f≠7.
  - Black (`turn`=1):
    - d=−8 needs `allow_q[0]`.
    - d=−16 needs `allow_q[1]`.
    - d=−9 needs `allow_q[2]` and f≠0.
    - d=−7 needs `allow_q[2]` and f≠7.
  - Any other d is illegal.
  - A destination off the board (src+d outside 0..63) is illegal.
  - Legal: pulse `move_valid`, update `move_src`/`move_dst`, toggle `turn`, increment `move_count`.
  - Illegal: pulse `move_err` with `err_code`=01; `turn` is unchanged.
  - Either outcome returns to IDLE.
- The checker is combinational, so `chk_pos`/`chk_color` drive it continuously. `allow_q` is the only sampled copy.

## Timing
- Reset (`reset`=0 at a rising edge), from any state including mid-move:
  - State returns to IDLE; `src`, `dst` and the counter clear.
  - `move_valid`, `move_err`, `busy`, `turn` and `move_count` go to 0; `err_code` goes to 00.
  - `move_src`, `move_dst` and `chk_pos` go to 0; `chk_color` goes to 0.
  - Reset overrides every other event in that cycle.
- All outputs are registered.
- Source latency: `sel_valid` in cycle N moves the state to SRC in N+1 (`busy`=1, `chk_pos`=src). WAIT_DST is entered in N+2.
- Destination latency: destination `sel_valid` in cycle M moves the state to CHECK in M+1. `move_valid` or `move_err` is high in M+2 only, together with IDLE and the new `turn`.
- A wrong-piece `move_err` is high in N+1.
- A timeout `move_err` occurs exactly TIMEOUT cycles after WAIT_DST is first entered, provided no `sel_valid` arrives.
- `move_valid` and `move_err` are never high in the same cycle.
- A new source may be selected in the cycle the pulse is high, since the state is already IDLE.

## Test plan
- White double step: `sel_pos`=12 (e2) with `piece_ok`=1, stub `chk_allow`=011, then `sel_pos`=28 → `move_valid` two cycles after the second strobe; `move_src`=12, `move_dst`=28, `turn`=1, `move_count`=1, `chk_color` was 0 during SRC.
- Black file-wrap capture: `turn`=1, src 48 (a7), `chk_allow`=100, dst 39 (d=−9, f=0) → `move_err`, `err_code`=01, `turn` stays 1, `move_count` unchanged.
- Timeout: TIMEOUT=16, valid source, then no strobes → `move_err` with `err_code`=10 exactly 16 cycles after WAIT_DST entry; `busy` falls in that same cycle.
- Cancel and wrong piece: reselect `src` in WAIT_DST → IDLE with no pulse. Then a strobe with `piece_ok`=0 → `move_err`, `err_code`=11 one cycle later, `busy` stays 0.
- Reset mid-move: assert `reset`=0 for one edge while in WAIT_DST after one committed move → IDLE, `turn`=0, `move_count`=0, no pulse. A following legal white move commits normally.
- Ignored strobes and counter wrap: `sel_valid` during SRC and CHECK has no effect. After 256 legal commits, `move_count` wraps to 0 and `turn` returns to 0.
